// File: rtl/wrr_pkt_arbiter.sv
// -----------------------------------------------------------------------------
// wrr_pkt_arbiter
// Packet-aware weighted round-robin arbiter. N valid/ready source streams
// share one sink stream. Once a source wins, the grant stays locked to it
// until the beat carrying last is accepted, so packets never interleave. A
// winner may send up to weight_i[winner] consecutive packets per turn. Each
// packet costs one IDLE cycle, which is spent on arbitration.
//
// Optional build macro: WRR_PKT_ARBITER_TIMEOUT_EN
//   Adds parameter TO_CYC and output timeout_o. A locked owner that holds
//   in_valid low for TO_CYC consecutive cycles loses its lock. Its remaining
//   credit is dropped, so the pointer rotates, and timeout_o pulses for one
//   cycle.
//
// Ports:
//   clk        clock
//   rst_n      asynchronous active-low reset
//   weight_i   packets per turn, source i at [i*WW +: WW] (0 behaves as 1)
//   in_valid   per-source beat valid
//   in_data    per-source data, source i at [i*DW +: DW]
//   in_last    per-source last beat of packet
//   in_ready   per-source ready (only the locked owner can see ready)
//   out_valid  merged stream valid
//   out_data   merged stream data
//   out_last   merged stream last
//   out_ready  sink ready
//   out_src    index of the current owner (meaningful while out_valid=1)
//   grant      one-hot owner, all zero in IDLE
//   timeout_o  one-cycle stall-timeout pulse (only with the macro)
// -----------------------------------------------------------------------------
module wrr_pkt_arbiter #(
  parameter int N  = 4,
  parameter int DW = 32,
  parameter int WW = 4
`ifdef WRR_PKT_ARBITER_TIMEOUT_EN
  ,
  parameter int TO_CYC = 255
`endif
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N*WW-1:0]      weight_i,
  input  logic [N-1:0]         in_valid,
  input  logic [N*DW-1:0]      in_data,
  input  logic [N-1:0]         in_last,
  output logic [N-1:0]         in_ready,
  output logic                 out_valid,
  output logic [DW-1:0]        out_data,
  output logic                 out_last,
  input  logic                 out_ready,
`ifdef WRR_PKT_ARBITER_TIMEOUT_EN
  output logic                 timeout_o,
`endif
  output logic [$clog2(N)-1:0] out_src,
  output logic [N-1:0]         grant
);

  localparam int SW = $clog2(N);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   grant_q, grant_d;
  logic [SW-1:0]  src_q, src_d;
  logic [SW-1:0]  ptr_q, ptr_d;
  logic [WW-1:0]  credit_q, credit_d;

`ifdef WRR_PKT_ARBITER_TIMEOUT_EN
  // The stall counter only needs to reach TO_CYC, but it is kept between
  // 8 and 16 bits wide.
  localparam int TOC = $clog2(TO_CYC + 1);
  localparam int TOW = (TOC < 8) ? 8 : ((TOC > 16) ? 16 : TOC);

  logic [TOW-1:0] stall_q, stall_d;
  logic           timeout_q, timeout_d;
`endif

  // Per-source views of the packed buses.
  logic [WW-1:0] weight_eff [N];
  logic [DW-1:0] data_arr   [N];

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_src
      // A weight of 0 would starve the source forever, so it is treated as 1.
      assign weight_eff[gi] = (weight_i[gi*WW +: WW] == '0) ? WW'(1)
                                                            : weight_i[gi*WW +: WW];
      assign data_arr[gi]   = in_data[gi*DW +: DW];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // IDLE pick. The current pointer is reused while it still has credit and is
  // requesting. Otherwise the scan starts at ptr+1 and wraps. The last scan
  // slot is ptr itself, so a lone requester is still served after its credit
  // runs out.
  // ---------------------------------------------------------------------------
  logic          pick_found;
  logic          pick_reuse;
  logic [SW-1:0] pick_idx;
  logic [SW:0]   cand;

  always_comb begin
    pick_found = 1'b0;
    pick_reuse = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    if ((credit_q != '0) && in_valid[ptr_q]) begin
      pick_found = 1'b1;
      pick_reuse = 1'b1;
      pick_idx   = ptr_q;
    end else begin
      for (int i = 1; i <= N; i++) begin
        cand = {1'b0, ptr_q} + (SW+1)'(i);
        if (cand >= (SW+1)'(N)) begin
          cand = cand - (SW+1)'(N);
        end
        if (!pick_found && in_valid[cand[SW-1:0]]) begin
          pick_found = 1'b1;
          pick_idx   = cand[SW-1:0];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Combinational datapath. While locked, the owner's stream passes straight
  // through. In IDLE, everything is held inactive.
  // ---------------------------------------------------------------------------
  logic own_valid;
  logic own_last;
  logic locked;
  logic hs;

  assign locked    = (state_q == LOCKED);
  assign own_valid = in_valid[src_q];
  assign own_last  = in_last[src_q];

  assign out_valid = locked & own_valid;
  assign out_last  = locked & own_last;
  assign out_data  = locked ? data_arr[src_q] : '0;
  assign in_ready  = locked ? (grant_q & {N{out_ready}}) : '0;
  assign out_src   = src_q;
  assign grant     = grant_q;
  assign hs        = out_valid & out_ready;

`ifdef WRR_PKT_ARBITER_TIMEOUT_EN
  assign timeout_o = timeout_q;
`endif

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    src_d    = src_q;
    ptr_d    = ptr_q;
    credit_d = credit_q;
`ifdef WRR_PKT_ARBITER_TIMEOUT_EN
    stall_d   = stall_q;
    timeout_d = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
`ifdef WRR_PKT_ARBITER_TIMEOUT_EN
        stall_d = '0;
`endif
        if (pick_found) begin
          state_d = LOCKED;
          grant_d = {{(N-1){1'b0}}, 1'b1} << pick_idx;
          src_d   = pick_idx;
          if (!pick_reuse) begin
            ptr_d    = pick_idx;
            credit_d = weight_eff[pick_idx];
          end
        end
      end
      LOCKED: begin
        if (hs && own_last) begin
          // One packet of this turn is spent. Once credit hits zero, the next
          // pick is forced to rotate.
          credit_d = (credit_q == '0) ? '0 : credit_q - WW'(1);
          grant_d  = '0;
          state_d  = IDLE;
`ifdef WRR_PKT_ARBITER_TIMEOUT_EN
          stall_d  = '0;
`endif
        end
`ifdef WRR_PKT_ARBITER_TIMEOUT_EN
        else if (!own_valid) begin
          if (stall_q >= TOW'(TO_CYC - 1)) begin
            // Abandon the stalled packet. Zero credit makes the pointer move on.
            credit_d  = '0;
            grant_d   = '0;
            state_d   = IDLE;
            stall_d   = '0;
            timeout_d = 1'b1;
          end else begin
            stall_d = stall_q + TOW'(1);
          end
        end else if (hs) begin
          stall_d = '0;
        end
`endif
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      src_q    <= '0;
      ptr_q    <= SW'(N - 1);  // source 0 wins the first scan
      credit_q <= '0;
`ifdef WRR_PKT_ARBITER_TIMEOUT_EN
      stall_q   <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      src_q    <= src_d;
      ptr_q    <= ptr_d;
      credit_q <= credit_d;
`ifdef WRR_PKT_ARBITER_TIMEOUT_EN
      stall_q   <= stall_d;
      timeout_q <= timeout_d;
`endif
    end
  end

endmodule

// File: tb/tb_wrr_pkt_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wrr_pkt_arbiter
// Directed bench for wrr_pkt_arbiter, with N=4, DW=32 and WW=4. Simple source
// models generate numbered packets. Every accepted output beat is logged and
// printed, and the log is compared against hand-derived sequences.
// -----------------------------------------------------------------------------
module tb_wrr_pkt_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int WW = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [N*WW-1:0]   weight_i;
  logic [N-1:0]      in_valid;
  logic [N*DW-1:0]   in_data;
  logic [N-1:0]      in_last;
  logic [N-1:0]      in_ready;
  logic              out_valid;
  logic [DW-1:0]     out_data;
  logic              out_last;
  logic              out_ready;
  logic [1:0]        out_src;
  logic [N-1:0]      grant;
`ifdef WRR_PKT_ARBITER_TIMEOUT_EN
  logic              timeout_o;
`endif

  always #5 clk = ~clk;

  wrr_pkt_arbiter #(
    .N (N),
    .DW(DW),
    .WW(WW)
`ifdef WRR_PKT_ARBITER_TIMEOUT_EN
    ,
    .TO_CYC(8)
`endif
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .weight_i (weight_i),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_last  (in_last),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_last (out_last),
    .out_ready(out_ready),
`ifdef WRR_PKT_ARBITER_TIMEOUT_EN
    .timeout_o(timeout_o),
`endif
    .out_src  (out_src),
    .grant    (grant)
  );

  // Source models
  logic src_en   [N];
  logic src_hold [N];
  int   src_len  [N];
  int   beat_cnt [N];
  int   pkt_cnt  [N];

  // Outputs sampled during the current tick
  logic [N-1:0]  s_grant;
  logic [N-1:0]  s_ready;
  logic          s_valid;
  logic          s_last;
  logic [DW-1:0] s_data;
  logic          s_to;

  // Log of accepted output beats
  int          log_src  [$];
  logic [31:0] log_data [$];
  logic        log_last [$];
  int          log_cyc  [$];

  int cyc;
  int errors;
  int checks;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mkdata(input int i, input int p, input int b);
    return (32'(i) << 16) | (32'(p & 255) << 8) | 32'(b & 255);
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      in_valid[i]            = src_en[i] & ~src_hold[i];
      in_data[i*DW +: DW]    = mkdata(i, pkt_cnt[i], beat_cnt[i]);
      in_last[i]             = (beat_cnt[i] == src_len[i] - 1);
    end
  endtask

  // Each tick starts at a negedge and covers one clock cycle. It drives the
  // inputs, samples the outputs, lets the DUT take the posedge, and then moves
  // the sources past any beats that were accepted.
  task automatic tick();
    logic [N-1:0] hs;
    drive();
    #1;
    s_grant = grant;
    s_ready = in_ready;
    s_valid = out_valid;
    s_last  = out_last;
    s_data  = out_data;
`ifdef WRR_PKT_ARBITER_TIMEOUT_EN
    s_to    = timeout_o;
`else
    s_to    = 1'b0;
`endif
    hs = in_valid & in_ready;
    if (out_valid && out_ready) begin
      log_src.push_back(int'(out_src));
      log_data.push_back(out_data);
      log_last.push_back(out_last);
      log_cyc.push_back(cyc);
      $display("beat cyc=%0d src=%0d data=%h last=%0d", cyc, out_src, out_data, out_last);
    end
    @(posedge clk);
    for (int i = 0; i < N; i++) begin
      if (hs[i]) begin
        if (in_last[i]) begin
          beat_cnt[i] = 0;
          pkt_cnt[i]  = pkt_cnt[i] + 1;
        end else begin
          beat_cnt[i] = beat_cnt[i] + 1;
        end
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic reset_all();
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) begin
      src_en[i]   = 1'b0;
      src_hold[i] = 1'b0;
      src_len[i]  = 1;
      beat_cnt[i] = 0;
      pkt_cnt[i]  = 0;
    end
    out_ready = 1'b1;
    weight_i  = {4'd1, 4'd1, 4'd1, 4'd1};
    log_src.delete();
    log_data.delete();
    log_last.delete();
    log_cyc.delete();
    drive();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
  endtask

  task automatic run_until(input int n, input int budget, input string tag);
    for (int c = 0; c < budget && log_src.size() < n; c++) tick();
    check({tag, "_beats"}, log_src.size() >= n, 1);
  endtask

  int e1 [5] = '{0, 1, 2, 3, 0};
  int p1 [5] = '{0, 0, 0, 0, 1};
  int e2 [9] = '{0, 0, 0, 1, 2, 3, 0, 0, 0};

  initial begin
    errors = 0;
    checks = 0;
    cyc    = 0;

    // ---- reset state, with every source requesting ----
    reset_all();
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) src_en[i] = 1'b1;
    drive();
    @(negedge clk);
    #1;
    check("rst_grant", grant, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_src", out_src, 0);

    // ---- test 1: 2-beat packets, weights 1, round-robin order ----
    reset_all();
    for (int i = 0; i < N; i++) begin
      src_en[i]  = 1'b1;
      src_len[i] = 2;
    end
    tick();
    check("t1_idle_grant", s_grant, 0);
    check("t1_idle_ready", s_ready, 0);
    run_until(10, 40, "t1");
    if (log_src.size() >= 10) begin
      check("t1_first_cyc", log_cyc[0], 1);
      for (int k = 0; k < 10; k++) begin
        check($sformatf("t1_src%0d", k), log_src[k], e1[k/2]);
        check($sformatf("t1_data%0d", k), log_data[k], mkdata(e1[k/2], p1[k/2], k % 2));
        check($sformatf("t1_last%0d", k), log_last[k], (k % 2) == 1);
        if (k > 0) check($sformatf("t1_gap%0d", k), log_cyc[k] - log_cyc[k-1],
                         ((k % 2) == 1) ? 1 : 2);
      end
    end

    // ---- test 2: source 0 weight 3, 1-beat packets ----
    reset_all();
    weight_i = {4'd1, 4'd1, 4'd1, 4'd3};
    for (int i = 0; i < N; i++) src_en[i] = 1'b1;
    run_until(9, 40, "t2");
    if (log_src.size() >= 9) begin
      for (int k = 0; k < 9; k++) begin
        check($sformatf("t2_src%0d", k), log_src[k], e2[k]);
        check($sformatf("t2_last%0d", k), log_last[k], 1);
        if (k > 0) check($sformatf("t2_gap%0d", k), log_cyc[k] - log_cyc[k-1], 2);
      end
    end

    // ---- test 3: owner 1 pauses mid-packet while source 2 is waiting ----
    reset_all();
    src_en[1] = 1'b1; src_len[1] = 4;
    src_en[2] = 1'b1; src_len[2] = 1;
    repeat (3) tick();
    src_hold[1] = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      check($sformatf("t3_grant_c%0d", c), s_grant, 4'b0010);
      check($sformatf("t3_ready2_c%0d", c), s_ready[2], 0);
      check($sformatf("t3_valid_c%0d", c), s_valid, 0);
    end
    src_hold[1] = 1'b0;
    run_until(5, 20, "t3");
    if (log_src.size() >= 5) begin
      for (int k = 0; k < 4; k++) begin
        check($sformatf("t3_src%0d", k), log_src[k], 1);
        check($sformatf("t3_data%0d", k), log_data[k], mkdata(1, 0, k));
        check($sformatf("t3_last%0d", k), log_last[k], k == 3);
      end
      check("t3_next_src", log_src[4], 2);
    end

    // ---- test 4: out_ready toggling on a 4-beat packet from source 3 ----
    reset_all();
    src_en[3] = 1'b1; src_len[3] = 4;
    out_ready = 1'b0;
    for (int c = 0; c < 30 && log_src.size() < 4; c++) begin
      out_ready = ~out_ready;
      tick();
      if (s_valid && !out_ready) begin
        check($sformatf("t4_stall_grant_c%0d", c), s_grant, 4'b1000);
        check($sformatf("t4_stall_data_c%0d", c), s_data, mkdata(3, 0, beat_cnt[3]));
        check($sformatf("t4_stall_last_c%0d", c), s_last, beat_cnt[3] == 3);
      end
    end
    check("t4_beats", log_src.size(), 4);
    if (log_src.size() >= 4) begin
      for (int k = 0; k < 4; k++) begin
        check($sformatf("t4_src%0d", k), log_src[k], 3);
        check($sformatf("t4_data%0d", k), log_data[k], mkdata(3, 0, k));
        check($sformatf("t4_last%0d", k), log_last[k], k == 3);
      end
    end
    out_ready = 1'b1;
    tick();
    check("t4_release_grant", s_grant, 0);

    // ---- test 5: asynchronous reset in the middle of a packet ----
    reset_all();
    for (int i = 0; i < N; i++) begin
      src_en[i]  = 1'b1;
      src_len[i] = 4;
    end
    repeat (3) tick();
    drive();
    #1;
    check("t5_pre_grant", grant, 4'b0001);
    rst_n = 1'b0;
    #1;
    check("t5_rst_grant", grant, 0);
    check("t5_rst_valid", out_valid, 0);
    check("t5_rst_ready", in_ready, 0);
    @(negedge clk);
    reset_all();
    for (int i = 0; i < N; i++) begin
      src_en[i]  = 1'b1;
      src_len[i] = 4;
    end
    run_until(1, 10, "t5");
    if (log_src.size() >= 1) begin
      check("t5_first_src", log_src[0], 0);
      check("t5_first_data", log_data[0], mkdata(0, 0, 0));
    end

`ifdef WRR_PKT_ARBITER_TIMEOUT_EN
    // ---- test 6: stall timeout hands the lock from owner 2 to source 3 ----
    begin
      int start;
      int pulses;
      int pcyc;
      int nb;
      reset_all();
      src_en[2] = 1'b1; src_len[2] = 4;
      src_en[3] = 1'b1; src_len[3] = 4;
      repeat (3) tick();
      check("t6_owner", s_grant, 4'b0100);
      src_hold[2] = 1'b1;
      start  = cyc;
      pulses = 0;
      pcyc   = -1;
      nb     = log_src.size();
      for (int c = 0; c < 12; c++) begin
        tick();
        if (s_to) begin
          pulses++;
          pcyc = cyc - 1 - start;
        end
      end
      check("t6_pulses", pulses, 1);
      check("t6_pulse_cyc", pcyc, 8);
      check("t6_new_beats", log_src.size() > nb, 1);
      if (log_src.size() > nb) check("t6_next_src", log_src[nb], 3);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wrr_pkt_arbiter.md
Name: wrr_pkt_arbiter

Overview:
- Packet-aware weighted round-robin arbiter that shares one valid/ready stream sink among N source streams.
- A grant is locked to one source from its first beat until its last beat is accepted, so packets never interleave.
- Each source may send up to its programmed weight of consecutive packets per turn.
- Sits in front of shared datapath resources (bus master port, shared FIFO) and supersedes per-cycle grant arbitration wherever transfers are multi-beat.

Parameters:
- N, 4, number of requesting streams (2..16).
- DW, 32, data width per stream.
- WW, 4, weight/credit counter width.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, asynchronous, active-low.
- weight_i  input  N*WW  packets per turn per source, slice i = [i*WW +: WW]; quasi-static; 0 is treated as 1.
- in_valid  input  N  per-source beat valid.
- in_data  input  N*DW  per-source data, slice i = [i*DW +: DW].
- in_last  input  N  per-source last beat of packet.
- in_ready  output  N  per-source ready.
- out_valid  output  1  merged stream valid.
- out_data  output  DW  merged data.
- out_last  output  1  merged last.
- out_ready  input  1  sink ready.
- out_src  output  $clog2(N)  index of the current owner; valid while out_valid=1.
- grant  output  N  one-hot owner; all zero in IDLE.

Behaviour:
- Reset values:
  - state=IDLE.
  - grant=0, in_ready=0, out_valid=0, out_last=0, out_data=0, out_src=0.
  - Pointer ptr=N-1, so source 0 wins first.
  - Credit counter=0.
- FSM has two states, IDLE and LOCKED. grant, out_src and credit are registers.
- IDLE, no in_valid set: stay in IDLE, outputs inactive.
- IDLE, some in_valid set, selection order:
  - If credit>0 and in_valid[ptr] is set, reselect ptr and keep credit.
  - Otherwise pick the first set in_valid scanning ptr+1, ptr+2, ... with wrap modulo N.
  - On a new pick, set ptr to the winner and load credit = max(weight_i[winner],1).
- IDLE winner handling:
  - Register grant/out_src for the winner and go to LOCKED next cycle.
  - Arbitration costs exactly one bubble cycle per packet.
  - in_ready is all zero in IDLE.
- LOCKED, with owner o:
  - out_valid=in_valid[o], out_data=in_data slice o, out_last=in_last[o].
  - in_ready[o]=out_ready; all other in_ready=0.
  - Datapath is combinational pass-through, zero added latency per beat.
- LOCKED release:
  - Handshake is out_valid & out_ready.
  - A handshake with out_last=1 decrements credit (saturating at 0), clears grant and returns to IDLE next cycle.
  - No other event releases the lock; the owner deasserting in_valid mid-packet keeps the lock.
- Credit exhaustion: credit reaching 0 forces rotation at the next IDLE pick, even if the owner is still valid.
- Credit with the owner idle: if credit>0 but in_valid[ptr]=0 in IDLE, the scan proceeds normally and the remaining credit is discarded (reloaded for the new winner).
- Single-beat packets (in_last on the first beat): one beat plus one IDLE cycle per packet; max throughput is 50%.
- Fairness: a source that holds valid is granted within (N-1) x max-weight packets.
- weight_i changes take effect only at the next credit load.
- rst_n asserted mid-packet: return to reset values immediately (asynchronous); the partial packet is dropped and the upstream source is responsible for recovery.
- Protocol assumption: upstream sources hold valid/data/last stable until ready.

Optional Feature:
- Macro: WRR_PKT_ARBITER_TIMEOUT_EN. When defined, it adds:
  - Parameter TO_CYC, default 255.
  - Output timeout_o (1 bit).
  - An 8..16-bit stall counter.
- Counter behaviour: in LOCKED, the counter increments each cycle in_valid[o]=0 and clears on any owner beat.
- On reaching TO_CYC:
  - Force release to IDLE with credit cleared, so the pointer rotates.
  - Pulse timeout_o high for one cycle.
  - No beat is emitted.
- When undefined: no port, no counter, and the lock is held indefinitely.

Test Plan:
- Reset, then all weights=1 and sources 0..3 each send one 2-beat packet continuously, out_ready=1 -> out_src order 0,1,2,3,0, each packet is 2 beats followed by 1 idle cycle, and the packets never interleave.
- weight_i={1,1,1,3} (source0=3), all sources always valid, 1-beat packets -> out_src sequence 0,0,0,1,2,3,0,0,0.
- Source 1 is granted and deasserts in_valid for 5 cycles mid-packet while source 2 is valid -> grant stays 0010, source 2 sees in_ready=0, and the packet resumes and completes intact.
- out_ready toggles every other cycle on a 4-beat packet from source 3 -> the 4 beats are transferred in order, out_data and out_last remain stable while stalled, and the release happens only after the last handshake.
- Assert rst_n low mid-packet -> the same cycle shows grant=0, out_valid=0 and in_ready=0; after release the first pick is source 0.
- With TIMEOUT_EN and TO_CYC=8, owner 2 stalls mid-packet with source 3 valid -> timeout_o pulses once after 8 stall cycles and the next out_src is 3.
